// File: rtl/memory_responder.sv
// Word-addressed 32-bit memory responder for the CPU datapath.
// It accepts one request at a time and pulses MemReady once per access after WAIT_STATES wait cycles.
module memory_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MARAddr,
  input  logic [31:0] MDRData,
  input  logic        Read,
  input  logic        Write,
  output logic [31:0] MdataOut,
  output logic        MemReady,
  output logic        Busy,
  output logic        AddrError
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             data_q;
  logic                    wr_q;
  logic                    aerr_q;
  logic [31:0]             mdata_q;
  logic [31:0]             mem_q [DEPTH];
  logic                    accept;

  assign accept = (state_q == S_IDLE) && (Read || Write);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request fields are captured only at acceptance, so later input changes cannot affect the access.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= MARAddr[ADDR_WIDTH-1:0];
      data_q <= MDRData;
      wr_q   <= Write;
      aerr_q <= |MARAddr[31:ADDR_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mdata_q <= 32'h0;
    end else if (state_q == S_ACCESS && !wr_q) begin
      mdata_q <= aerr_q ? 32'h0 : mem_q[addr_q];
    end
  end

  // Reset on the ACCESS edge must abort the write.
  always_ff @(posedge clk) begin
    if (!reset && state_q == S_ACCESS && wr_q && !aerr_q) begin
      mem_q[addr_q] <= data_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (Read || Write) begin
          if (WAIT_STATES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Busy      = (state_q != S_IDLE);
    MemReady  = (state_q == S_DONE);
    AddrError = (state_q == S_DONE) && aerr_q;
  end

  assign MdataOut = mdata_q;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: instance 0 uses two wait states, instance 1 uses none.
// A request-level model predicts every output each cycle; directed vectors add literal expectations.
module tb_memory_responder;

  logic        clk;
  logic        rst  [2];
  logic [31:0] addr [2];
  logic [31:0] wd   [2];
  logic        rd   [2];
  logic        wr   [2];
  logic [31:0] mdo  [2];
  logic        rdy  [2];
  logic        bsy  [2];
  logic        aer  [2];

  int checks = 0;
  int errors = 0;

  memory_responder #(.ADDR_WIDTH(9), .WAIT_STATES(2)) dut0 (
    .clk(clk), .reset(rst[0]), .MARAddr(addr[0]), .MDRData(wd[0]),
    .Read(rd[0]), .Write(wr[0]), .MdataOut(mdo[0]), .MemReady(rdy[0]),
    .Busy(bsy[0]), .AddrError(aer[0]));

  memory_responder #(.ADDR_WIDTH(9), .WAIT_STATES(0)) dut1 (
    .clk(clk), .reset(rst[1]), .MARAddr(addr[1]), .MDRData(wd[1]),
    .Read(rd[1]), .Write(wr[1]), .MdataOut(mdo[1]), .MemReady(rdy[1]),
    .Busy(bsy[1]), .AddrError(aer[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Request-level model: one outstanding request, timed by edge count from acceptance.
  int          n;
  logic        seen  [2];
  logic        pend  [2];
  int          e0    [2];
  logic        mwr   [2];
  logic        merr  [2];
  logic [8:0]  maddr [2];
  logic [31:0] mdat  [2];
  logic [31:0] emd   [2];
  logic [31:0] mmem  [2][512];

  initial begin
    n = 0;
    for (int d = 0; d < 2; d++) begin
      seen[d] = 1'b0;
      pend[d] = 1'b0;
      e0[d]   = 0;
      emd[d]  = 32'h0;
    end
    forever begin
      @(posedge clk);
      n++;
      for (int d = 0; d < 2; d++) begin
        if (rst[d]) begin
          pend[d] = 1'b0;
          emd[d]  = 32'h0;
          seen[d] = 1'b1;
        end else if (!pend[d]) begin
          if (rd[d] || wr[d]) begin
            pend[d]  = 1'b1;
            e0[d]    = n;
            mwr[d]   = wr[d];
            merr[d]  = |addr[d][31:9];
            maddr[d] = addr[d][8:0];
            mdat[d]  = wd[d];
          end
        end else begin
          if (n == e0[d] + ws_of(d) + 1) begin
            if (mwr[d] && !merr[d]) mmem[d][maddr[d]] = mdat[d];
            else if (!mwr[d])       emd[d] = merr[d] ? 32'h0 : mmem[d][maddr[d]];
          end
          if (n == e0[d] + ws_of(d) + 2) pend[d] = 1'b0;
        end
      end
    end
  end

  initial begin
    logic er;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (seen[d]) begin
          er = pend[d] && (n == e0[d] + ws_of(d) + 1);
          chk($sformatf("cyc_busy%0d", d),  {31'h0, bsy[d]}, {31'h0, pend[d]});
          chk($sformatf("cyc_ready%0d", d), {31'h0, rdy[d]}, {31'h0, er});
          chk($sformatf("cyc_aerr%0d", d),  {31'h0, aer[d]}, {31'h0, er && merr[d]});
          chk($sformatf("cyc_mdata%0d", d), mdo[d], emd[d]);
        end
      end
    end
  end

  int          lat_o, bcnt_o, rcnt_o;
  logic        aerr_o;
  logic [31:0] md_o;

  // mode 1: retarget address and raise Write during WAIT; mode 2: reset during ACCESS.
  task automatic req(input int d, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] dat, input int mode);
    rd[d] = r; wr[d] = w; addr[d] = a; wd[d] = dat;
    @(posedge clk); #2;
    rd[d] = 1'b0; wr[d] = 1'b0;
    lat_o = -1; bcnt_o = 0; rcnt_o = 0; aerr_o = 1'b0; md_o = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mode == 1 && i == 0) begin addr[d] = 32'h20; wd[d] = 32'h99; wr[d] = 1'b1; end
      if (mode == 1 && i == 3) wr[d] = 1'b0;
      if (mode == 2 && i == 2) rst[d] = 1'b1;
      if (mode == 2 && i == 3) rst[d] = 1'b0;
      if (bsy[d]) bcnt_o++;
      if (rdy[d]) begin
        rcnt_o++;
        if (lat_o < 0) lat_o = i;
        aerr_o = aer[d];
        md_o   = mdo[d];
      end
    end
    @(posedge clk); #2;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = 32'h0; wd[d] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #2;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    chk("rst_mdata",  mdo[0], 32'h0);
    chk("rst_ready",  {31'h0, rdy[0]}, 32'h0);
    chk("rst_busy",   {31'h0, bsy[0]}, 32'h0);
    chk("rst_aerr",   {31'h0, aer[0]}, 32'h0);
    @(posedge clk); #2;

    req(0, 1'b0, 1'b1, 32'h005, 32'hDEADBEEF, 0);
    chk("wr5_lat", lat_o, 3);
    chk("wr5_pulses", rcnt_o, 1);
    chk("wr5_mdata", md_o, 32'h0);
    req(0, 1'b1, 1'b0, 32'h005, 32'h0, 0);
    chk("rd5_data", md_o, 32'hDEADBEEF);
    chk("rd5_lat", lat_o, 3);

    req(1, 1'b0, 1'b1, 32'h1FF, 32'h12345678, 0);
    chk("ws0_wr_lat", lat_o, 1);
    req(1, 1'b1, 1'b0, 32'h1FF, 32'h0, 0);
    chk("ws0_rd_data", md_o, 32'h12345678);
    chk("ws0_rd_lat", lat_o, 1);
    chk("ws0_busy_cycles", bcnt_o, 2);

    req(0, 1'b0, 1'b1, 32'h205, 32'hAAAA5555, 0);
    chk("oor_wr_aerr", {31'h0, aerr_o}, 32'h1);
    chk("oor_wr_pulses", rcnt_o, 1);
    req(0, 1'b1, 1'b0, 32'h005, 32'h0, 0);
    chk("oor_alias_data", md_o, 32'hDEADBEEF);
    chk("oor_alias_aerr", {31'h0, aerr_o}, 32'h0);
    req(0, 1'b1, 1'b0, 32'h205, 32'h0, 0);
    chk("oor_rd_data", md_o, 32'h0);
    chk("oor_rd_aerr", {31'h0, aerr_o}, 32'h1);

    req(0, 1'b0, 1'b1, 32'h010, 32'h11, 0);
    req(0, 1'b0, 1'b1, 32'h020, 32'h22, 0);
    req(0, 1'b1, 1'b0, 32'h010, 32'h0, 1);
    chk("busy_ign_data", md_o, 32'h11);
    chk("busy_ign_pulses", rcnt_o, 1);
    req(0, 1'b1, 1'b0, 32'h020, 32'h0, 0);
    chk("busy_ign_loc20", md_o, 32'h22);

    req(0, 1'b1, 1'b1, 32'h030, 32'h33, 0);
    chk("rw_pulses", rcnt_o, 1);
    chk("rw_mdata_kept", md_o, 32'h22);
    req(0, 1'b1, 1'b0, 32'h030, 32'h0, 0);
    chk("rw_readback", md_o, 32'h33);

    req(0, 1'b0, 1'b1, 32'h007, 32'h1, 0);
    req(0, 1'b0, 1'b1, 32'h007, 32'hCAFEF00D, 2);
    chk("rstmid_pulses", rcnt_o, 0);
    chk("rstmid_busy_cycles", bcnt_o, 3);
    chk("rstmid_mdata", mdo[0], 32'h0);
    chk("rstmid_idle", {31'h0, bsy[0]}, 32'h0);
    req(0, 1'b1, 1'b0, 32'h007, 32'h0, 0);
    chk("rstmid_readback", md_o, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
# memory_responder

Synchronous word-addressed memory that answers the CPU datapath's memory requests. It receives an address from MAR, write data from MDR, and Read/Write strobes. It returns read data on the MDR's memory-data input, with a one-cycle completion pulse after a programmable number of wait states. The control unit uses MemReady to advance out of its memory-wait step.

## Interface
Parameters:
- ADDR_WIDTH, 9: number of word-address bits; depth is 2^ADDR_WIDTH words of 32 bits.
- WAIT_STATES, 2: extra wait cycles per access; legal range 0..15.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- MARAddr  in  32  word address. Bits [ADDR_WIDTH-1:0] index the array; the upper bits must be zero.
- MDRData  in  32  write data.
- Read  in  1  read request; sampled only in IDLE.
- Write  in  1  write request; sampled only in IDLE; takes priority over Read.
- MdataOut  out  32  read data to the MDR memory-data input; registered.
- MemReady  out  1  completion pulse, exactly one cycle per accepted request.
- Busy  out  1  high whenever the state is not IDLE.
- AddrError  out  1  high with MemReady when the completed access had nonzero upper address bits.

## Operation
States: IDLE, WAIT, ACCESS, DONE.

- **IDLE**
  - A request is accepted at an edge where Read or Write is high.
  - On acceptance, latch MARAddr, MDRData, op (Write if Write is high, else Read), and the address-error flag (`|MARAddr[31:ADDR_WIDTH]`).
  - Next state is ACCESS if WAIT_STATES = 0. Otherwise next state is WAIT, with the counter loaded to WAIT_STATES-1.
- **WAIT**
  - Counter = 0 → ACCESS; otherwise decrement the counter.
  - WAIT lasts exactly WAIT_STATES cycles.
- **ACCESS** (one cycle)
  - Write with no address error: array[addr] ← latched data at the edge leaving ACCESS.
  - Read with no address error: MdataOut ← array[addr] at that same edge.
  - Read with an address error: MdataOut ← 0.
  - Write with an address error: the array is unchanged.
  - Next state is DONE.
- **DONE** (one cycle)
  - MemReady = 1; AddrError = latched flag.
  - Next state is IDLE.
- Request inputs are ignored outside IDLE. Changes to MARAddr, MDRData, Read or Write during WAIT, ACCESS or DONE have no effect.
- MdataOut holds its last read result until the next completed read. Writes never change MdataOut.
- Array contents are not cleared by reset. A read of a never-written location returns an undefined value.

## Timing
- Reset values: state IDLE, counter 0, MdataOut 0x00000000, MemReady 0, Busy 0, AddrError 0. Reset overrides every transition.
- Let E0 be the accepting edge. Busy is high from E0 until the edge ending DONE.
- MemReady is high for the single cycle following edge E0+WAIT_STATES+1.
- MdataOut is valid in that same cycle and stays valid afterwards.
- Minimum request-to-request spacing is WAIT_STATES+3 cycles. A strobe held high in the cycle DONE returns to IDLE is accepted on the next edge, as a new request.
- Reset during WAIT or ACCESS:
  - The access is aborted and no array write occurs, even if reset coincides with the ACCESS edge.
  - MemReady is not pulsed.
  - MdataOut is cleared to 0.
- Read and Write high together: treated as a write. Only one MemReady pulse is produced.
- Address wrap-around is not performed. Out-of-range addresses are reported through AddrError and never alias.

## Test plan
- **Reset values:** WAIT_STATES = 2; hold reset for 2 cycles → MdataOut = 0, MemReady = 0, Busy = 0, AddrError = 0.
- **Write then read:**
  - Write 0xDEADBEEF to address 0x005 → MemReady pulses once, 3 edges after acceptance; MdataOut stays 0.
  - Then read address 0x005 → MdataOut = 0xDEADBEEF in the MemReady cycle.
- **Zero wait states:** WAIT_STATES = 0; read address 0x1FF after writing 0x12345678 → MemReady in the cycle after edge E0+1; Busy high for exactly 2 cycles.
- **Out-of-range address:**
  - Write 0xAAAA5555 to 0x00000205 (ADDR_WIDTH = 9) → AddrError = 1 with MemReady.
  - A subsequent read of 0x005 returns its old value; a read of 0x205 returns 0 with AddrError = 1.
- **Inputs ignored while busy:**
  - Read 0x010 (holding 0x11), then change MARAddr to 0x020 and raise Write during WAIT → MdataOut = 0x11; location 0x020 is unchanged.
  - Simultaneous Read+Write at IDLE performs a write.
- **Reset mid-write:** accept a write of 0xCAFEF00D to 0x007 (old value 0x1); assert reset in the ACCESS cycle → no MemReady pulse, state IDLE, and a later read of 0x007 returns 0x1.
